imem_fetch_ctrl: RTL and testbench

//  Sequencer for the 128x32 instruction memory. At boot it fills memory from a byte

---
 rtl/imem_pkg.sv | 20 ++
 rtl/imem_byte_packer.sv | 72 +++++++
 rtl/imem_fetch_ctrl.sv | 158 +++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : imem_pkg
// Brief    : Shared types and constants for the instruction-memory fetch path.
// Revision : 1.0 - initial release
// ============================================================================
package imem_pkg;

    localparam int          IMEM_DEPTH   = 128;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_byte_packer.sv
`default_nettype none
// ============================================================================
// Module   : imem_byte_packer
// Brief    : Assembles little-endian boot bytes into 32-bit imem write beats.
// Revision : 1.0 - initial release
// ============================================================================
module imem_byte_packer #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          accept,
    input  logic [7:0]    ld_byte,
    input  logic          ld_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic          final_write
);

    logic [1:0]    r_byte_cnt;
    logic [31:0]   r_acc;
    logic [AW-1:0] r_word_idx;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [31:0]   r_wdata;
    logic          r_final;

    logic [31:0]   w_merged;
    logic          w_word_done;
    logic          w_last_word;

    // Accumulator restarts from zero at lane 0, so unfilled upper lanes stay zero.
    assign w_merged    = ((r_byte_cnt == 2'd0) ? 32'd0 : r_acc)
                       | ({24'd0, ld_byte} << {r_byte_cnt, 3'b000});
    assign w_word_done = (r_byte_cnt == 2'd3) || ld_last;
    assign w_last_word = ld_last || (r_word_idx == AW'(DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_byte_cnt <= 2'd0;
            r_acc      <= 32'd0;
            r_word_idx <= '0;
            r_we       <= 1'b0;
            r_waddr    <= '0;
            r_wdata    <= 32'd0;
            r_final    <= 1'b0;
        end else begin
            r_we    <= 1'b0;
            r_final <= 1'b0;
            if (accept) begin
                r_acc      <= w_merged;
                r_byte_cnt <= ld_last ? 2'd0 : r_byte_cnt + 2'd1;
                if (w_word_done) begin
                    r_we       <= 1'b1;
                    r_waddr    <= r_word_idx;
                    r_wdata    <= w_merged;
                    r_word_idx <= r_word_idx + 1'b1;
                    r_final    <= w_last_word;
                end
            end
        end
    end

    assign imem_we     = r_we;
    assign imem_waddr  = r_waddr;
    assign imem_wdata  = r_wdata;
    assign final_write = r_final;

endmodule
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : imem_fetch_ctrl
// Brief    : Boot loader and PC/fetch sequencer for the 128x32 instruction memory.
// Revision : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int          DEPTH    = IMEM_DEPTH,
    parameter int          AW       = 7,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    output logic          ld_ready,
    input  logic          ld_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_waddr,
    output logic [31:0]   imem_wdata,
    output logic [31:0]   imem_raddr,
    input  logic [31:0]   imem_rdata,
    input  logic          stall,
    input  logic          redirect,
    input  logic [31:0]   redirect_pc,
    output logic          f_valid,
    output logic [31:0]   f_pc,
    output logic [31:0]   f_instr,
    output logic          running,
    output logic          halted,
    output logic          fault
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic        r_f_valid;
    logic [31:0] r_f_pc;
    logic [31:0] r_f_instr;
    logic        r_fault;

    logic        w_final_write;
    logic        w_accept;
    logic        w_pc_ok;
    logic        w_take_redirect;
    logic        w_issue;
    logic        w_raise_fault;
    logic        w_ebreak_halt;

    // Ready drops during the final write beat so no byte past the image is taken.
    assign ld_ready = (r_state == LOAD) && !w_final_write;
    assign w_accept = ld_valid && ld_ready;
    assign w_pc_ok  = (r_pc[1:0] == 2'b00) && (r_pc[31:AW+2] == '0);

    imem_byte_packer #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .accept      (w_accept),
        .ld_byte     (ld_byte),
        .ld_last     (ld_last),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .final_write (w_final_write)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_take_redirect = 1'b0;
        w_issue         = 1'b0;
        w_raise_fault   = 1'b0;
        w_ebreak_halt   = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_final_write) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                // A presented EBREAK beat ends fetching regardless of other controls.
                if (r_f_valid && (r_f_instr == INSTR_EBREAK)) begin
                    w_ebreak_halt = 1'b1;
                    w_state_next  = HALT;
                end else if (redirect) begin
                    w_take_redirect = 1'b1;
                end else if (!stall) begin
                    if (w_pc_ok) begin
                        w_issue = 1'b1;
                    end else begin
                        w_raise_fault = 1'b1;
                        w_state_next  = HALT;
                    end
                end
            end
            HALT: begin
                w_state_next = HALT;
            end
            default: begin
                w_state_next = LOAD;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_f_valid <= 1'b0;
            r_f_pc    <= 32'd0;
            r_f_instr <= 32'd0;
            r_fault   <= 1'b0;
        end else begin
            if ((r_state == LOAD) && w_final_write) begin
                r_pc <= RESET_PC;
            end
            if (w_take_redirect) begin
                r_pc      <= redirect_pc;
                r_f_valid <= 1'b0;
            end
            if (w_issue) begin
                r_f_pc    <= r_pc;
                r_f_instr <= imem_rdata;
                r_f_valid <= 1'b1;
                r_pc      <= r_pc + 32'd4;
            end
            if (w_raise_fault) begin
                r_fault   <= 1'b1;
                r_f_valid <= 1'b0;
            end
            if (w_ebreak_halt) begin
                r_f_valid <= 1'b0;
            end
        end
    end

    assign imem_raddr = (r_state == RUN) ? 32'(r_pc[AW+1:2]) : 32'd0;
    assign f_valid    = r_f_valid;
    assign f_pc       = r_f_pc;
    assign f_instr    = r_f_instr;
    assign running    = (r_state == RUN);
    assign halted     = (r_state == HALT);
    assign fault      = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_fetch_ctrl
// Brief    : Randomised bench for imem_fetch_ctrl against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_fetch_ctrl;
    import imem_pkg::*;

    localparam int MS_LOAD = 0;
    localparam int MS_RUN  = 1;
    localparam int MS_HALT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        ld_last;
    logic        imem_we;
    logic [6:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] imem_raddr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        f_valid;
    logic [31:0] f_pc;
    logic [31:0] f_instr;
    logic        running;
    logic        halted;
    logic        fault;

    int n_checks = 0;
    int n_fail   = 0;

    imem_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_valid    (ld_valid),
        .ld_byte     (ld_byte),
        .ld_ready    (ld_ready),
        .ld_last     (ld_last),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .imem_raddr  (imem_raddr),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .f_valid     (f_valid),
        .f_pc        (f_pc),
        .f_instr     (f_instr),
        .running     (running),
        .halted      (halted),
        .fault       (fault)
    );

    always #5 clk = ~clk;

    // Instruction memory with a write port and combinational read
    logic [31:0] mem [0:127];
    always @(posedge clk) if (imem_we) mem[imem_waddr] <= imem_wdata;
    assign imem_rdata = mem[imem_raddr[6:0]];

    // Reference model state
    int          m_state;
    bit          m_fin;
    bit          m_we;
    int          m_widx;
    logic [6:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [7:0]  m_cur [$];
    logic [31:0] m_pc;
    bit          m_fvalid;
    logic [31:0] m_fpc;
    logic [31:0] m_finstr;
    bit          m_fault;
    logic [31:0] m_mem [0:127];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [31:0] word;
        if (!rst_n) begin
            m_state = MS_LOAD; m_fin = 0; m_we = 0; m_widx = 0; m_cur.delete();
            m_waddr = 0; m_wdata = 0;
            m_pc = 0; m_fvalid = 0; m_fpc = 0; m_finstr = 0; m_fault = 0;
        end else begin
            case (m_state)
                MS_LOAD: begin
                    m_we = 0;
                    if (m_fin) begin
                        m_state = MS_RUN; m_fin = 0; m_pc = 0;
                    end else if (ld_valid) begin
                        m_cur.push_back(ld_byte);
                        if (m_cur.size() == 4 || ld_last) begin
                            word = 0;
                            foreach (m_cur[i]) word = word | (32'(m_cur[i]) << (8 * i));
                            m_we = 1; m_waddr = 7'(m_widx); m_wdata = word;
                            m_mem[m_widx] = word;
                            m_fin = ld_last || (m_widx == 127);
                            m_widx++;
                            m_cur.delete();
                        end
                    end
                end
                MS_RUN: begin
                    if (m_fvalid && m_finstr == INSTR_EBREAK) begin
                        m_state = MS_HALT; m_fvalid = 0;
                    end else if (redirect) begin
                        m_fvalid = 0; m_pc = redirect_pc;
                    end else if (!stall) begin
                        if (m_pc % 4 != 0 || m_pc >= 512) begin
                            m_fault = 1; m_state = MS_HALT; m_fvalid = 0;
                        end else begin
                            m_fvalid = 1; m_fpc = m_pc; m_finstr = m_mem[m_pc / 4];
                            m_pc = m_pc + 32'd4;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_all();
        check_eq("ld_ready", 32'(ld_ready), 32'(m_state == MS_LOAD && !m_fin));
        check_eq("imem_we", 32'(imem_we), 32'(m_we));
        if (m_we) begin
            check_eq("imem_waddr", 32'(imem_waddr), 32'(m_waddr));
            check_eq("imem_wdata", imem_wdata, m_wdata);
        end
        check_eq("running", 32'(running), 32'(m_state == MS_RUN));
        check_eq("halted", 32'(halted), 32'(m_state == MS_HALT));
        check_eq("fault", 32'(fault), 32'(m_fault));
        check_eq("imem_raddr", imem_raddr, (m_state == MS_RUN) ? ((m_pc >> 2) & 32'd127) : 32'd0);
        check_eq("f_valid", 32'(f_valid), 32'(m_fvalid));
        if (m_fvalid) begin
            check_eq("f_pc", f_pc, m_fpc);
            check_eq("f_instr", f_instr, m_finstr);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        ld_valid = 0; ld_byte = 0; ld_last = 0;
        stall = 0; redirect = 0; redirect_pc = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        cycle();
        check_eq("rst_f_pc", f_pc, 32'd0);
        check_eq("rst_f_instr", f_instr, 32'd0);
        check_eq("rst_waddr", 32'(imem_waddr), 32'd0);
        check_eq("rst_wdata", imem_wdata, 32'd0);
        rst_n = 1;
    endtask

    task automatic send_bytes(input logic [7:0] bytes [$], input bit with_last, input int gap_pct);
        foreach (bytes[i]) begin
            while (($urandom % 100) < 32'(gap_pct)) begin
                ld_valid = 0;
                cycle();
            end
            ld_valid = 1; ld_byte = bytes[i];
            ld_last  = with_last && (i == bytes.size() - 1);
            cycle();
        end
        ld_valid = 0; ld_last = 0; ld_byte = 0;
        cycle();
        cycle();
    endtask

    function automatic logic [31:0] pick_target();
        int r;
        r = int'($urandom % 10);
        if (r < 7)       return ($urandom % 128) * 4;
        else if (r == 7) return 32'd512 + ($urandom % 64) * 4;
        else if (r == 8) return ($urandom % 128) * 4 + 1 + ($urandom % 3);
        else             return 32'd508;
    endfunction

    task automatic run_random(input int n, input int stall_pct, input int redir_pct);
        for (int i = 0; i < n; i++) begin
            stall       = ($urandom % 100) < 32'(stall_pct);
            redirect    = ($urandom % 100) < 32'(redir_pct);
            redirect_pc = pick_target();
            cycle();
        end
        stall = 0; redirect = 0;
    endtask

    task automatic push_word(inout logic [7:0] q [$], input logic [31:0] w);
        for (int k = 0; k < 4; k++) q.push_back(w[8*k +: 8]);
    endtask

    initial begin
        logic [7:0] img [$];
        bit         found;

        for (int i = 0; i < 128; i++) begin
            mem[i]   = INSTR_NOP;
            m_mem[i] = INSTR_NOP;
        end
        rst_n = 0;
        idle_inputs();

        // Two-word image, back-to-back bytes
        do_reset();
        img = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        send_bytes(img, 1, 0);
        run_random(4, 0, 0);

        // Partial final word padded with zeros
        do_reset();
        img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hA5};
        send_bytes(img, 1, 30);
        run_random(3, 0, 0);

        // Stall hold at f_pc=0x8, then redirect+stall to 0x40
        do_reset();
        img.delete();
        for (int w = 0; w < 20; w++) push_word(img, 32'h0000_0093 + (w << 20));
        send_bytes(img, 1, 0);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = f_valid && (f_pc == 32'h8);
        end
        check_eq("wait_fpc8", 32'(found), 32'd1);
        stall = 1;
        for (int i = 0; i < 3; i++) cycle();
        stall = 0;
        cycle();
        stall = 1; redirect = 1; redirect_pc = 32'h40;
        cycle();
        stall = 0; redirect = 0;
        run_random(3, 0, 0);

        // Misaligned and out-of-range redirect targets
        redirect = 1; redirect_pc = 32'h42;
        cycle();
        redirect = 0;
        run_random(3, 0, 0);
        redirect = 1; redirect_pc = 32'h40;
        cycle();
        redirect = 0;
        do_reset();
        send_bytes(img, 1, 0);
        cycle();
        redirect = 1; redirect_pc = 32'h200;
        cycle();
        redirect = 0;
        run_random(3, 0, 0);

        // EBREAK at word 3, then reset in HALT and mid-LOAD
        do_reset();
        img.delete();
        for (int w = 0; w < 3; w++) push_word(img, INSTR_NOP);
        push_word(img, INSTR_EBREAK);
        push_word(img, INSTR_NOP);
        send_bytes(img, 1, 0);
        run_random(8, 0, 0);
        do_reset();
        cycle();
        ld_valid = 1; ld_byte = 8'h5A;
        cycle();
        cycle();
        do_reset();
        cycle();

        // Full-depth image without ld_last; extra bytes must be refused
        img.delete();
        for (int i = 0; i < 520; i++) img.push_back(8'($urandom));
        send_bytes(img, 0, 0);
        run_random(40, 20, 5);

        // Randomised images and fetch control
        for (int it = 0; it < 20; it++) begin
            do_reset();
            img.delete();
            for (int i = 0; i < int'($urandom_range(1, 64)); i++) img.push_back(8'($urandom));
            if ($urandom % 4 == 0) push_word(img, INSTR_EBREAK);
            send_bytes(img, 1, 25);
            run_random(60, 30, 8);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
